// File: rtl/fir_cap_pkg.sv
// rtl/fir_cap_pkg.sv - shared constants and round/saturate helper for the FIR result capture block
// Contents: default parameter values, CALC_W working width, scale_sat() round-and-clip function.

package fir_cap_pkg;

    localparam int OW_DEF     = 31;
    localparam int DW_DEF     = 16;
    localparam int SHIFT_DEF  = 11;
    localparam int DEPTH_DEF  = 8;
    localparam int WARMUP_DEF = 5;

    // Working width for scaling; wide enough that the rounding bias can never
    // overflow for any practical accumulator width.
    localparam int CALC_W = 64;

    // Round half toward +inf, arithmetic shift right, then clip to a signed
    // dw-bit range. The result is returned sign-extended to CALC_W bits.
    function automatic logic signed [CALC_W-1:0] scale_sat(
        input  logic signed [CALC_W-1:0] value,
        input  int                       dw,
        input  int                       shift,
        output logic                     clipped
    );
        logic signed [CALC_W-1:0] biased;
        logic signed [CALC_W-1:0] v;
        logic signed [CALC_W-1:0] max_v;
        logic signed [CALC_W-1:0] min_v;
        logic signed [CALC_W-1:0] result;
        biased = value;
        if (shift > 0) begin
            biased = value + (64'sd1 <<< (shift - 1));
        end
        v       = biased >>> shift;
        max_v   = (64'sd1 <<< (dw - 1)) - 64'sd1;
        min_v   = -(64'sd1 <<< (dw - 1));
        clipped = 1'b0;
        result  = v;
        if (v > max_v) begin
            result  = max_v;
            clipped = 1'b1;
        end else if (v < min_v) begin
            result  = min_v;
            clipped = 1'b1;
        end
        return result;
    endfunction

endpackage

// File: rtl/fir_cap_fifo.sv
// rtl/fir_cap_fifo.sv - synchronous show-ahead FIFO with registered head, level and flags
// Ports: clk, resetn (sync active-low), clear (sync flush), wr_en/wr_data push,
//        rd_en pop, rd_data registered head (0 when empty), empty, full, level.

module fir_cap_fifo #(
    parameter int DEPTH = 8,
    parameter int DW    = 16
) (
    input  logic                       clk,
    input  logic                       resetn,
    input  logic                       clear,
    input  logic                       wr_en,
    input  logic [DW-1:0]              wr_data,
    input  logic                       rd_en,
    output logic [DW-1:0]              rd_data,
    output logic                       empty,
    output logic                       full,
    output logic [$clog2(DEPTH+1)-1:0] level
);

    localparam int AW = $clog2(DEPTH);
    localparam int LW = $clog2(DEPTH + 1);

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic [LW-1:0] count;

    logic          flush;
    logic          do_rd;
    logic          do_wr;
    logic [LW-1:0] count_n;
    logic [AW-1:0] rd_ptr_n;
    logic [DW-1:0] head_n;

    assign flush = !resetn || clear;

    always_comb begin
        do_rd    = 1'b0;
        do_wr    = 1'b0;
        count_n  = count;
        rd_ptr_n = rd_ptr;
        head_n   = '0;
        if (!flush) begin
            do_rd = rd_en && (count != '0);
            // A pop in the same cycle frees the slot, so a full FIFO still accepts.
            do_wr = wr_en && ((count != LW'(DEPTH)) || do_rd);
        end
        count_n  = count + LW'(do_wr) - LW'(do_rd);
        rd_ptr_n = rd_ptr + AW'(do_rd);
        if (count_n == '0) begin
            head_n = '0;
        end else if ((count - LW'(do_rd)) == '0) begin
            // Only the incoming word will be held; it is not in mem yet.
            head_n = wr_data;
        end else begin
            head_n = mem[rd_ptr_n];
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (flush) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            count   <= '0;
            rd_data <= '0;
            empty   <= 1'b1;
            full    <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr + AW'(do_wr);
            rd_ptr  <= rd_ptr_n;
            count   <= count_n;
            rd_data <= head_n;
            empty   <= (count_n == '0);
            full    <= (count_n == LW'(DEPTH));
        end
    end

    assign level = count;

endmodule

// File: rtl/fir_result_capture.sv
// rtl/fir_result_capture.sv - captures, rounds and saturates FIR outputs into a host-drained FIFO
// Ports: i_clk, i_reset_n (sync active-low), i_ce sample strobe, i_result accumulator,
//        i_clear sync flush, i_rd_en pop; o_rd_data show-ahead head, o_empty, o_full,
//        o_level, o_overflow / o_sat sticky flags.

module fir_result_capture
    import fir_cap_pkg::*;
#(
    parameter int OW     = OW_DEF,
    parameter int DW     = DW_DEF,
    parameter int SHIFT  = SHIFT_DEF,
    parameter int DEPTH  = DEPTH_DEF,
    parameter int WARMUP = WARMUP_DEF
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_ce,
    input  logic signed [OW-1:0]       i_result,
    input  logic                       i_clear,
    input  logic                       i_rd_en,
    output logic signed [DW-1:0]       o_rd_data,
    output logic                       o_empty,
    output logic                       o_full,
    output logic [$clog2(DEPTH+1)-1:0] o_level,
    output logic                       o_overflow,
    output logic                       o_sat
);

    localparam int WC_W = (WARMUP > 0) ? $clog2(WARMUP + 1) : 1;

    logic                     flush;
    logic                     pending;
    logic [WC_W-1:0]          warm_cnt;
    logic                     warm_done;
    logic                     wr_en;
    logic                     dropped;
    logic                     clipped;
    logic signed [CALC_W-1:0] scaled_full;
    logic [DW-1:0]            scaled;
    logic [DW-1:0]            fifo_rd_data;
    logic                     unused_scaled_hi;

    assign flush     = !i_reset_n || i_clear;
    assign warm_done = (warm_cnt == WC_W'(WARMUP));
    // The FIR output for a strobe appears one cycle later, so a result is
    // processed in the cycle after i_ce.
    assign wr_en     = pending && warm_done && !flush;
    assign dropped   = wr_en && o_full && !i_rd_en;

    always_comb begin
        clipped     = 1'b0;
        scaled_full = scale_sat(CALC_W'(i_result), DW, SHIFT, clipped);
    end

    assign scaled           = scaled_full[DW-1:0];
    assign unused_scaled_hi = ^scaled_full[CALC_W-1:DW];

    always_ff @(posedge i_clk) begin
        if (flush) begin
            pending    <= 1'b0;
            warm_cnt   <= '0;
            o_overflow <= 1'b0;
            o_sat      <= 1'b0;
        end else begin
            pending <= i_ce;
            if (pending && !warm_done) begin
                warm_cnt <= warm_cnt + WC_W'(1);
            end
            if (dropped) begin
                o_overflow <= 1'b1;
            end
            // Only clipping of a word that actually lands in the FIFO counts.
            if (wr_en && clipped && !dropped) begin
                o_sat <= 1'b1;
            end
        end
    end

    fir_cap_fifo #(
        .DEPTH (DEPTH),
        .DW    (DW)
    ) u_fifo (
        .clk     (i_clk),
        .resetn  (i_reset_n),
        .clear   (i_clear),
        .wr_en   (wr_en),
        .wr_data (scaled),
        .rd_en   (i_rd_en),
        .rd_data (fifo_rd_data),
        .empty   (o_empty),
        .full    (o_full),
        .level   (o_level)
    );

    assign o_rd_data = fifo_rd_data;

endmodule

// File: tb/tb_fir_result_capture.sv
// tb/tb_fir_result_capture.sv - directed self-checking bench for fir_result_capture

module tb_fir_result_capture;

    logic               clk;
    logic               reset_n;
    logic               ce;
    logic signed [30:0] result;
    logic               clear;
    logic               rd_en;
    logic signed [15:0] rd_data;
    logic               empty;
    logic               full;
    logic [3:0]         level;
    logic               overflow;
    logic               sat;

    int n_checks = 0;
    int n_pass   = 0;

    fir_result_capture dut (
        .i_clk      (clk),
        .i_reset_n  (reset_n),
        .i_ce       (ce),
        .i_result   (result),
        .i_clear    (clear),
        .i_rd_en    (rd_en),
        .o_rd_data  (rd_data),
        .o_empty    (empty),
        .o_full     (full),
        .o_level    (level),
        .o_overflow (overflow),
        .o_sat      (sat)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got == exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Strobe for one cycle, hold the value through the processing cycle.
    task automatic push(input int v);
        result = 31'(v);
        ce     = 1'b1;
        step();
        ce     = 1'b0;
        step();
    endtask

    task automatic pop();
        rd_en = 1'b1;
        step();
        rd_en = 1'b0;
    endtask

    task automatic do_clear();
        clear = 1'b1;
        step();
        clear = 1'b0;
    endtask

    initial begin
        int round_in  [4] = '{3072, -3072, 1023, 1024};
        int round_exp [4] = '{2, -1, 0, 1};

        reset_n = 1'b0;
        ce      = 1'b0;
        result  = '0;
        clear   = 1'b0;
        rd_en   = 1'b0;

        // Reset with strobe toggling
        result = 31'(4096);
        for (int i = 0; i < 3; i++) begin
            ce = ~ce;
            step();
        end
        ce = 1'b0;
        check("rst_empty", empty, 1);
        check("rst_full", full, 0);
        check("rst_level", level, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_overflow", overflow, 0);
        check("rst_sat", sat, 0);
        reset_n = 1'b1;
        step();

        // Warm-up discards
        for (int i = 0; i < 5; i++) push(4096);
        check("warm_empty", empty, 1);
        check("warm_level", level, 0);
        push(4096);
        check("warm6_level", level, 1);
        check("warm6_data", rd_data, 2);
        pop();
        check("warm6_popped", empty, 1);

        // Rounding
        for (int i = 0; i < 4; i++) begin
            push(round_in[i]);
            check($sformatf("round_%0d", round_in[i]), rd_data, round_exp[i]);
            pop();
        end
        check("round_sat", sat, 0);

        // Saturation
        push(1 << 29);
        check("sat_pos_data", rd_data, 32767);
        check("sat_pos_flag", sat, 1);
        pop();
        push(-(1 << 29));
        check("sat_neg_data", rd_data, -32768);
        pop();
        check("sat_sticky", sat, 1);
        do_clear();
        check("sat_cleared", sat, 0);

        // Full and overflow
        for (int i = 0; i < 5; i++) push(0);
        check("refill_warm_empty", empty, 1);
        for (int k = 1; k <= 8; k++) push(k * 2048);
        check("full_flag", full, 1);
        check("full_level", level, 8);
        check("full_no_ovf", overflow, 0);
        push(9 * 2048);
        check("ovf_flag", overflow, 1);
        check("ovf_level", level, 8);
        for (int k = 1; k <= 8; k++) begin
            check($sformatf("drain_%0d", k), rd_data, k);
            pop();
        end
        check("drain_empty", empty, 1);

        // Refill and write+pop while full
        do_clear();
        for (int i = 0; i < 5; i++) push(0);
        for (int k = 11; k <= 18; k++) push(k * 2048);
        check("refill_full", full, 1);
        result = 31'(100 * 2048);
        ce     = 1'b1;
        step();
        ce     = 1'b0;
        rd_en  = 1'b1;
        step();
        rd_en  = 1'b0;
        check("wrpop_level", level, 8);
        check("wrpop_ovf", overflow, 0);
        check("wrpop_head", rd_data, 12);
        for (int k = 12; k <= 18; k++) begin
            check($sformatf("wrpop_drain_%0d", k), rd_data, k);
            pop();
        end
        check("wrpop_last", rd_data, 100);
        pop();
        check("wrpop_empty", empty, 1);

        // Clear mid-stream
        push(1 << 29);
        push(2048);
        push(2 * 2048);
        check("mid_level", level, 3);
        check("mid_sat", sat, 1);
        result = 31'(5 * 2048);
        clear  = 1'b1;
        rd_en  = 1'b1;
        ce     = 1'b1;
        step();
        clear  = 1'b0;
        rd_en  = 1'b0;
        ce     = 1'b0;
        check("clr_level", level, 0);
        check("clr_empty", empty, 1);
        check("clr_data", rd_data, 0);
        check("clr_sat", sat, 0);
        check("clr_ovf", overflow, 0);
        step();
        check("clr_after_level", level, 0);
        for (int i = 0; i < 5; i++) push(3 * 2048);
        check("clr_warm_empty", empty, 1);
        push(7 * 2048);
        check("clr_post_level", level, 1);
        check("clr_post_data", rd_data, 7);
        pop();
        pop();
        check("rd_empty_level", level, 0);
        check("rd_empty_empty", empty, 1);
        check("rd_empty_data", rd_data, 0);
        check("rd_empty_ovf", overflow, 0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
